// File: rtl/switches_debounce_ctrl.sv
// Avalon-MM switch controller: per-bit sync + debounce,
// rising-edge capture with W1C clear and maskable irq.
module switches_debounce_ctrl #(
    parameter int WIDTH           = 9,
    parameter int DEBOUNCE_CYCLES = 50000,
    parameter int CNT_W           = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [1:0]       address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic [WIDTH-1:0] writedata,
    input  logic [WIDTH-1:0] in_port,
    output logic [WIDTH-1:0] readdata,
    output logic             irq
);

    localparam logic [CNT_W-1:0] CNT_LAST =
        CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [WIDTH-1:0] sync1;
    logic [WIDTH-1:0] sync_q;
    logic [WIDTH-1:0] stable;
    logic [WIDTH-1:0] stable_d;
    logic [WIDTH-1:0] rise;
    logic [WIDTH-1:0] clr;
    logic [WIDTH-1:0] edge_capture;
    logic [WIDTH-1:0] irq_mask;
    logic [CNT_W-1:0] cnt   [WIDTH];
    logic [CNT_W-1:0] cnt_d [WIDTH];
    logic             wr_en;

    assign wr_en = chipselect & ~write_n;

    // Per-bit debounce: count consecutive mismatches, accept at the limit
    always_comb begin
        stable_d = stable;
        for (int i = 0; i < WIDTH; i++) begin
            cnt_d[i] = '0;
            if (sync_q[i] != stable[i]) begin
                if (cnt[i] == CNT_LAST) begin
                    stable_d[i] = sync_q[i];
                end else begin
                    cnt_d[i] = cnt[i] + CNT_W'(1);
                end
            end
        end
        rise = stable_d & ~stable;
        clr  = (wr_en && address == 2'd3) ? writedata : '0;
    end

    // Two-flop synchroniser, debounce counters and accepted levels
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync1  <= '0;
            sync_q <= '0;
            stable <= '0;
            for (int i = 0; i < WIDTH; i++) begin
                cnt[i] <= '0;
            end
        end else begin
            sync1  <= in_port;
            sync_q <= sync1;
            stable <= stable_d;
            for (int i = 0; i < WIDTH; i++) begin
                cnt[i] <= cnt_d[i];
            end
        end
    end

    // Edge capture: a new press beats a same-cycle W1C clear
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            edge_capture <= '0;
        end else begin
            edge_capture <= (edge_capture & ~clr) | rise;
        end
    end

    // Interrupt mask register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            irq_mask <= '0;
        end else if (wr_en && address == 2'd2) begin
            irq_mask <= writedata;
        end
    end

    // Registered read mux, one cycle latency like the PIO slaves
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            readdata <= '0;
        end else begin
            unique case (address)
                2'd0: readdata <= stable;
                2'd1: readdata <= sync_q;
                2'd2: readdata <= irq_mask;
                2'd3: readdata <= edge_capture;
            endcase
        end
    end

    assign irq = |(edge_capture & irq_mask);

endmodule

// File: tb/tb_switches_debounce_ctrl.sv
// Bench for switches_debounce_ctrl: directed plan steps plus
// random bouncing inputs, checked by a queue-based scoreboard.
module tb_switches_debounce_ctrl;

    localparam int W = 9;
    localparam int D = 4;

    logic         clk = 1'b0;
    logic         reset_n;
    logic [1:0]   address;
    logic         chipselect;
    logic         write_n;
    logic [W-1:0] writedata;
    logic [W-1:0] in_port;
    logic [W-1:0] readdata;
    logic         irq;

    int n_cmp = 0;
    int n_bad = 0;

    switches_debounce_ctrl #(
        .WIDTH(W),
        .DEBOUNCE_CYCLES(D),
        .CNT_W(16)
    ) dut (
        .clk(clk),
        .reset_n(reset_n),
        .address(address),
        .chipselect(chipselect),
        .write_n(write_n),
        .writedata(writedata),
        .in_port(in_port),
        .readdata(readdata),
        .irq(irq)
    );

    always #5 clk = ~clk;

    // Reference model state: values are "after the last edge"
    logic [W-1:0] m_sync1, m_sync, m_stable, m_ec, m_mask;
    logic [W-1:0] hist[$];
    logic [W:0]   sb[$];

    task automatic model_clear();
        m_sync1  = '0;
        m_sync   = '0;
        m_stable = '0;
        m_ec     = '0;
        m_mask   = '0;
        hist.delete();
    endtask

    // Model: a level is accepted once the synchronised value has
    // disagreed with the accepted level on D consecutive edges.
    always @(posedge clk) begin
        logic [W-1:0] rd, nst, clr;
        bit           all_diff;
        if (!reset_n) begin
            model_clear();
            sb.push_back('0);
        end else begin
            case (address)
                2'd0: rd = m_stable;
                2'd1: rd = m_sync;
                2'd2: rd = m_mask;
                default: rd = m_ec;
            endcase
            hist.push_back(m_sync);
            if (hist.size() > D) void'(hist.pop_front());
            nst = m_stable;
            for (int b = 0; b < W; b++) begin
                all_diff = (hist.size() == D);
                foreach (hist[k])
                    if (hist[k][b] == m_stable[b]) all_diff = 0;
                if (all_diff) nst[b] = ~m_stable[b];
            end
            clr = (chipselect && !write_n && address == 2'd3)
                  ? writedata : '0;
            m_ec = (m_ec & ~clr) | (nst & ~m_stable);
            if (chipselect && !write_n && address == 2'd2)
                m_mask = writedata;
            m_stable = nst;
            m_sync   = m_sync1;
            m_sync1  = in_port;
            sb.push_back({|(m_ec & m_mask), rd});
        end
    end

    // Monitor: DUT presents readdata/irq every cycle
    always @(negedge clk) begin
        logic [W:0] e;
        n_cmp++;
        if (sb.size() == 0) begin
            n_bad++;
            $display("FAIL sb_empty t=%0t", $time);
        end else begin
            e = sb.pop_front();
            if (readdata !== e[W-1:0]) begin
                n_bad++;
                $display("FAIL sb_readdata t=%0t got %h want %h",
                         $time, readdata, e[W-1:0]);
            end
            n_cmp++;
            if (irq !== e[W]) begin
                n_bad++;
                $display("FAIL sb_irq t=%0t got %b want %b",
                         $time, irq, e[W]);
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic chk(input string nm, input logic [W-1:0] act,
                       input logic [W-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s t=%0t got %h want %h",
                     nm, $time, act, exp);
        end
    endtask

    task automatic rst_on();
        reset_n = 1'b0;
        sb.delete();
        model_clear();
        sb.push_back('0);
    endtask

    task automatic rst_off();
        tick(2);
        reset_n = 1'b1;
    endtask

    task automatic wr_reg(input logic [1:0] a, input logic [W-1:0] d);
        chipselect = 1'b1;
        write_n    = 1'b0;
        address    = a;
        writedata  = d;
        tick(1);
        chipselect = 1'b0;
        write_n    = 1'b1;
    endtask

    task automatic rd_reg(input logic [1:0] a, output logic [W-1:0] d);
        address = a;
        tick(1);
        d = readdata;
    endtask

    task automatic fresh();
        in_port = '0;
        address = 2'd0;
        rst_on();
        rst_off();
    endtask

    initial begin
        #2_000_000;
        n_bad++;
        $display("FAIL watchdog t=%0t", $time);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $fatal(1, "timeout");
    end

    initial begin
        logic [W-1:0] v;
        logic [W-1:0] tgt;
        logic [6:0]   bounce;
        reset_n    = 1'b1;
        address    = 2'd0;
        chipselect = 1'b0;
        write_n    = 1'b1;
        writedata  = '0;
        in_port    = '0;
        #1 reset_n = 1'b0;
        tick(3);
        reset_n = 1'b1;

        // 1. reset values, then reset mid-count
        tick(3);
        chk("rst_readdata", readdata, '0);
        chk("rst_irq", {8'd0, irq}, '0);
        in_port = 9'h1FF;
        address = 2'd1;
        tick(3);
        chk("sync_before_rst", readdata, 9'h1FF);
        rst_on();
        #1;
        chk("async_rst_readdata", readdata, '0);
        chk("async_rst_irq", {8'd0, irq}, '0);
        address = 2'd0;
        rst_off();
        tick(6);
        chk("post_rst_edge6", readdata, '0);
        tick(1);
        chk("post_rst_edge7", readdata, 9'h1FF);

        // 2. glitch of D-1 cycles, then bounce pattern
        fresh();
        tick(4);
        in_port = 9'h001;
        tick(3);
        in_port = 9'h000;
        for (int k = 0; k < 4; k++) begin
            rd_reg(2'd0, v);
            chk("glitch_stable", v, '0);
            rd_reg(2'd3, v);
            chk("glitch_edge", v, '0);
        end
        address = 2'd0;
        bounce  = 7'b1111011;
        for (int k = 0; k < 7; k++) begin
            in_port = {8'd0, bounce[k]};
            tick(1);
        end
        tick(2);
        chk("bounce_edge9", readdata, '0);
        tick(1);
        chk("bounce_edge10", readdata, 9'h001);

        // 3. latency on stable and sync paths
        fresh();
        in_port = 9'h101;
        tick(6);
        chk("lat_stable_e6", readdata, '0);
        tick(1);
        chk("lat_stable_e7", readdata, 9'h101);
        fresh();
        in_port = 9'h101;
        address = 2'd1;
        tick(2);
        chk("lat_sync_e2", readdata, '0);
        tick(1);
        chk("lat_sync_e3", readdata, 9'h101);

        // 4. interrupt, W1C, masked press
        fresh();
        wr_reg(2'd2, 9'h001);
        in_port = 9'h001;
        tick(6);
        chk("irq_on_press", {8'd0, irq}, 9'h001);
        rd_reg(2'd3, v);
        chk("edge_bit0", v, 9'h001);
        wr_reg(2'd3, 9'h001);
        chk("irq_after_w1c", {8'd0, irq}, '0);
        in_port = 9'h003;
        tick(6);
        chk("irq_masked", {8'd0, irq}, '0);
        rd_reg(2'd3, v);
        chk("edge_bit1", v, 9'h002);

        // 5. W1C colliding with a rising edge
        fresh();
        wr_reg(2'd2, 9'h004);
        in_port = 9'h004;
        tick(5);
        chipselect = 1'b1;
        write_n    = 1'b0;
        address    = 2'd3;
        writedata  = 9'h004;
        tick(1);
        chipselect = 1'b0;
        write_n    = 1'b1;
        chk("collide_irq", {8'd0, irq}, 9'h001);
        rd_reg(2'd3, v);
        chk("collide_edge", v, 9'h004);

        // 6. release is not captured; read-only writes ignored
        fresh();
        in_port = 9'h008;
        tick(8);
        in_port = 9'h000;
        address = 2'd0;
        tick(6);
        chk("release_e6", readdata, 9'h008);
        tick(1);
        chk("release_e7", readdata, '0);
        rd_reg(2'd3, v);
        chk("release_edge", v, 9'h008);
        wr_reg(2'd0, 9'h1FF);
        wr_reg(2'd1, 9'h1FF);
        rd_reg(2'd0, v);
        chk("ro_stable", v, '0);
        rd_reg(2'd1, v);
        chk("ro_sync", v, '0);
        rd_reg(2'd2, v);
        chk("ro_mask", v, '0);
        rd_reg(2'd3, v);
        chk("ro_edge", v, 9'h008);

        // Random bouncing inputs and bus traffic
        fresh();
        tgt = '0;
        for (int k = 0; k < 1500; k++) begin
            if ($urandom_range(0, 5) == 0)
                tgt[$urandom_range(0, W - 1)] ^= 1'b1;
            v = tgt;
            if ($urandom_range(0, 3) == 0)
                v[$urandom_range(0, W - 1)] ^= 1'b1;
            in_port    = v;
            address    = 2'($urandom_range(0, 3));
            chipselect = ($urandom_range(0, 7) == 0);
            write_n    = ($urandom_range(0, 1) == 0);
            writedata  = W'($urandom);
            tick(1);
        end
        chipselect = 1'b0;
        write_n    = 1'b1;
        tick(3);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
